// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared constants, mix FSM encoding and clog2 helper for the tone mixer
package audio_pkg;

   localparam logic [1:0] MODE_SQUARE = 2'd0;
   localparam logic [1:0] MODE_SAW    = 2'd1;
   localparam logic [1:0] MODE_TRI    = 2'd2;
   localparam logic [1:0] MODE_MUTE   = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_STEP = 2'd1,
      ST_MIX  = 2'd2,
      ST_DONE = 2'd3
   } mix_state_e;

   // Constant-foldable ceil(log2(value)); clog2(1) is 0.
   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) result = i + 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/audio_tone_mixer_i2s_tx.sv
// rtl/audio_tone_mixer_i2s_tx.sv - I2S serialiser slaved to codec-mastered BCLK/LRCK
module i2s_tx
   import audio_pkg::*;
#(
   parameter int SAMPLE_W = 16
) (
   input  logic                CLK,
   input  logic                RST,
   input  logic                AUD_BCLK,
   input  logic                AUD_DACLRCK,
   input  logic [SAMPLE_W-1:0] left,
   input  logic [SAMPLE_W-1:0] right,
   output logic                AUD_DACDAT,
   output logic                frame_start
);

   localparam int CNT_W = clog2(SAMPLE_W + 1);

   logic [1:0]          bclk_sync_q, bclk_sync_d;
   logic [1:0]          lrck_sync_q, lrck_sync_d;
   logic                bclk_prev_q, bclk_prev_d;
   logic                lrck_prev_q, lrck_prev_d;
   logic [SAMPLE_W-1:0] shift_q, shift_d;
   logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
   logic                dat_q, dat_d;
   logic                fall_tick;
   logic                frame_edge;

   always_comb begin
      bclk_sync_d = {bclk_sync_q[0], AUD_BCLK};
      lrck_sync_d = {lrck_sync_q[0], AUD_DACLRCK};
      bclk_prev_d = bclk_sync_q[1];
      lrck_prev_d = lrck_prev_q;
      shift_d     = shift_q;
      bit_cnt_d   = bit_cnt_q;
      dat_d       = dat_q;
      fall_tick   = bclk_prev_q & ~bclk_sync_q[1];
      frame_edge  = fall_tick & (lrck_sync_q[1] != lrck_prev_q);
      frame_start = frame_edge & ~lrck_sync_q[1];

      // The frame-edge tick drives 0; the MSB follows one BCLK later.
      if (fall_tick) begin
         lrck_prev_d = lrck_sync_q[1];
         if (frame_edge) begin
            shift_d   = lrck_sync_q[1] ? right : left;
            bit_cnt_d = '0;
            dat_d     = 1'b0;
         end else if (bit_cnt_q < CNT_W'(SAMPLE_W)) begin
            dat_d     = shift_q[SAMPLE_W-1];
            shift_d   = {shift_q[SAMPLE_W-2:0], 1'b0};
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
         end else begin
            dat_d = 1'b0;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (!RST) begin
         bclk_sync_q <= 2'b00;
         lrck_sync_q <= 2'b11;
         bclk_prev_q <= 1'b0;
         lrck_prev_q <= 1'b1;
         shift_q     <= '0;
         bit_cnt_q   <= CNT_W'(SAMPLE_W);
         dat_q       <= 1'b0;
      end else begin
         bclk_sync_q <= bclk_sync_d;
         lrck_sync_q <= lrck_sync_d;
         bclk_prev_q <= bclk_prev_d;
         lrck_prev_q <= lrck_prev_d;
         shift_q     <= shift_d;
         bit_cnt_q   <= bit_cnt_d;
         dat_q       <= dat_d;
      end
   end

   assign AUD_DACDAT = dat_q;

endmodule

// File: rtl/audio_tone_mixer.sv
// rtl/audio_tone_mixer.sv - phase-accumulator voices, per-frame left/right mix FSM, I2S output
module audio_tone_mixer
   import audio_pkg::*;
#(
   parameter int CHANNELS = 4,
   parameter int ACC_W    = 24,
   parameter int SAMPLE_W = 16
) (
   input  logic                      CLK,
   input  logic                      RST,
   input  logic                      AUD_BCLK,
   input  logic                      AUD_DACLRCK,
   output logic                      AUD_DACDAT,
   input  logic [CHANNELS*ACC_W-1:0] ch_inc,
   input  logic [2*CHANNELS-1:0]     ch_mode,
   input  logic [CHANNELS-1:0]       ch_right,
   input  logic [CHANNELS-1:0]       ch_en,
   output logic                      frame_pulse
);

   localparam int LOG_CH = clog2(CHANNELS);
   localparam int SUM_W  = SAMPLE_W + LOG_CH;
   localparam int IDX_W  = (LOG_CH > 0) ? LOG_CH : 1;
   localparam logic [SAMPLE_W-1:0] AMP_POS  = {1'b0, {(SAMPLE_W-1){1'b1}}};
   localparam logic [SAMPLE_W-1:0] AMP_NEG  = {1'b1, {(SAMPLE_W-2){1'b0}}, 1'b1};
   localparam logic [SAMPLE_W-1:0] MOST_NEG = {1'b1, {(SAMPLE_W-1){1'b0}}};

   mix_state_e                 state_q, state_d;
   logic [IDX_W-1:0]           voice_q, voice_d;
   logic [ACC_W-1:0]           phase_q [CHANNELS];
   logic [ACC_W-1:0]           phase_d [CHANNELS];
   logic signed [SUM_W-1:0]    sum_l_q, sum_l_d, sum_r_q, sum_r_d;
   logic [SAMPLE_W-1:0]        next_l_q, next_l_d, next_r_q, next_r_d;
   logic [SAMPLE_W-1:0]        hold_l_q, hold_l_d, hold_r_q, hold_r_d;
   logic                       frame_pulse_q, frame_pulse_d;
   logic                       frame_start;
   logic signed [SAMPLE_W-1:0] voice_sample;
   logic                       voice_en;
   logic                       voice_right;

   function automatic logic [SAMPLE_W-1:0] wave(input logic [SAMPLE_W-1:0] p,
                                               input logic [1:0] mode);
      logic [SAMPLE_W-2:0] fold;
      logic [SAMPLE_W-1:0] tri_val;
      fold    = p[SAMPLE_W-2:0] ^ {(SAMPLE_W-1){p[SAMPLE_W-1]}};
      tri_val = {~fold[SAMPLE_W-2], fold[SAMPLE_W-3:0], 1'b0};
      case (mode)
         MODE_SQUARE: wave = p[SAMPLE_W-1] ? AMP_NEG : AMP_POS;
         MODE_SAW:    wave = {~p[SAMPLE_W-1], p[SAMPLE_W-2:0]};
         MODE_TRI:    wave = (tri_val == MOST_NEG) ? AMP_NEG : tri_val;
         default:     wave = '0;
      endcase
   endfunction

   always_comb begin
      voice_sample = '0;
      voice_en     = 1'b0;
      voice_right  = 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
         if (voice_q == IDX_W'(i)) begin
            voice_sample = wave(phase_q[i][ACC_W-1 -: SAMPLE_W], ch_mode[2*i +: 2]);
            voice_en     = ch_en[i];
            voice_right  = ch_right[i];
         end
      end
   end

   // Hold takes the finished mix exactly when the left word is loaded, so the
   // serialiser is fed the incoming value rather than the stale register.
   always_comb begin
      state_d       = state_q;
      voice_d       = voice_q;
      phase_d       = phase_q;
      sum_l_d       = sum_l_q;
      sum_r_d       = sum_r_q;
      next_l_d      = next_l_q;
      next_r_d      = next_r_q;
      hold_l_d      = frame_start ? next_l_q : hold_l_q;
      hold_r_d      = frame_start ? next_r_q : hold_r_q;
      frame_pulse_d = frame_start;
      case (state_q)
         ST_STEP: begin
            for (int i = 0; i < CHANNELS; i++) begin
               if (ch_en[i]) phase_d[i] = phase_q[i] + ch_inc[i*ACC_W +: ACC_W];
            end
            sum_l_d = '0;
            sum_r_d = '0;
            voice_d = '0;
            state_d = ST_MIX;
         end
         ST_MIX: begin
            if (voice_en) begin
               if (voice_right) sum_r_d = sum_r_q + SUM_W'(voice_sample);
               else             sum_l_d = sum_l_q + SUM_W'(voice_sample);
            end
            voice_d = voice_q + IDX_W'(1);
            if (voice_q == IDX_W'(CHANNELS - 1)) state_d = ST_DONE;
         end
         ST_DONE: begin
            next_l_d = SAMPLE_W'(sum_l_q >>> LOG_CH);
            next_r_d = SAMPLE_W'(sum_r_q >>> LOG_CH);
            state_d  = ST_IDLE;
         end
         default: ;
      endcase
      if (frame_start) state_d = ST_STEP;
   end

   always_ff @(posedge CLK) begin
      if (!RST) begin
         state_q       <= ST_IDLE;
         voice_q       <= '0;
         for (int i = 0; i < CHANNELS; i++) phase_q[i] <= '0;
         sum_l_q       <= '0;
         sum_r_q       <= '0;
         next_l_q      <= '0;
         next_r_q      <= '0;
         hold_l_q      <= '0;
         hold_r_q      <= '0;
         frame_pulse_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         voice_q       <= voice_d;
         phase_q       <= phase_d;
         sum_l_q       <= sum_l_d;
         sum_r_q       <= sum_r_d;
         next_l_q      <= next_l_d;
         next_r_q      <= next_r_d;
         hold_l_q      <= hold_l_d;
         hold_r_q      <= hold_r_d;
         frame_pulse_q <= frame_pulse_d;
      end
   end

   i2s_tx #(
      .SAMPLE_W(SAMPLE_W)
   ) u_i2s_tx (
      .CLK         (CLK),
      .RST         (RST),
      .AUD_BCLK    (AUD_BCLK),
      .AUD_DACLRCK (AUD_DACLRCK),
      .left        (hold_l_d),
      .right       (hold_r_d),
      .AUD_DACDAT  (AUD_DACDAT),
      .frame_start (frame_start)
   );

   assign frame_pulse = frame_pulse_q;

endmodule

// File: tb/tb_audio_tone_mixer.sv
// tb/tb_audio_tone_mixer.sv - randomized frame-level bench for audio_tone_mixer
module tb_audio_tone_mixer;

   localparam int CH   = 4;
   localparam int AW   = 24;
   localparam int SW   = 16;
   localparam int HALF = 52;
   localparam int AMP  = 2**(SW-1) - 1;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            bclk = 1'b1;
   logic            lrck = 1'b1;
   logic            dacdat;
   logic            frame_pulse;
   logic [CH*AW-1:0] ch_inc = '0;
   logic [2*CH-1:0]  ch_mode = '0;
   logic [CH-1:0]    ch_right = '0;
   logic [CH-1:0]    ch_en = '0;

   int pass_cnt  = 0;
   int check_cnt = 0;
   int pulse_cnt = 0;
   int frame_no  = 0;

   logic [AW-1:0] m_phase [CH];
   int            m_prev_l = 0;
   int            m_prev_r = 0;

   audio_tone_mixer #(
      .CHANNELS(CH),
      .ACC_W   (AW),
      .SAMPLE_W(SW)
   ) dut (
      .CLK        (clk),
      .RST        (rst_n),
      .AUD_BCLK   (bclk),
      .AUD_DACLRCK(lrck),
      .AUD_DACDAT (dacdat),
      .ch_inc     (ch_inc),
      .ch_mode    (ch_mode),
      .ch_right   (ch_right),
      .ch_en      (ch_en),
      .frame_pulse(frame_pulse)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (frame_pulse === 1'b1) pulse_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      check_cnt++;
      if (got === exp) pass_cnt++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   function automatic int voice_value(input logic [AW-1:0] phase, input logic [1:0] mode);
      int p, frac, t, v;
      p = int'(phase[AW-1 -: SW]);
      v = 0;
      case (mode)
         2'd0: v = (p >= 2**(SW-1)) ? -AMP : AMP;
         2'd1: v = p - 2**(SW-1);
         2'd2: begin
            frac = p % (2**(SW-1));
            t    = (p >= 2**(SW-1)) ? (2**(SW-1) - 1 - frac) : frac;
            v    = 2 * t - 2**(SW-1);
            if (v < -AMP) v = -AMP;
         end
         default: v = 0;
      endcase
      return v;
   endfunction

   // Expected words for this frame are last frame's mix; then mix this frame.
   task automatic model_frame(output int exp_l, output int exp_r);
      int sum_l, sum_r, v;
      exp_l = m_prev_l;
      exp_r = m_prev_r;
      sum_l = 0;
      sum_r = 0;
      for (int i = 0; i < CH; i++) begin
         if (ch_en[i]) begin
            m_phase[i] = m_phase[i] + ch_inc[i*AW +: AW];
            v = voice_value(m_phase[i], ch_mode[2*i +: 2]);
            if (ch_right[i]) sum_r += v;
            else             sum_l += v;
         end
      end
      m_prev_l = sum_l >>> $clog2(CH);
      m_prev_r = sum_r >>> $clog2(CH);
   endtask

   task automatic run_half(input logic side, input int rst_bit,
                           output logic [SW-1:0] word, output logic tail);
      word = '0;
      tail = 1'b0;
      for (int b = 0; b < 32; b++) begin
         #HALF bclk = 1'b0;
         if (b == 0) lrck = side;
         #HALF bclk = 1'b1;
         if (b >= 1 && b <= SW) word = {word[SW-2:0], dacdat};
         else                   tail = tail | dacdat;
         if (b == rst_bit) begin
            @(negedge clk) rst_n = 1'b0;
            @(negedge clk);
            check("reset_dacdat", 32'(dacdat), 0);
            check("reset_frame_pulse", 32'(frame_pulse), 0);
            rst_n = 1'b1;
         end
      end
   endtask

   task automatic run_frame(input int rst_bit);
      int exp_l, exp_r, pulses0;
      logic [SW-1:0] wl, wr;
      logic tl, tr;
      model_frame(exp_l, exp_r);
      pulses0 = pulse_cnt;
      run_half(1'b0, -1, wl, tl);
      check($sformatf("frame_pulse[%0d]", frame_no), 32'(pulse_cnt - pulses0), 1);
      check($sformatf("left_word[%0d]", frame_no), 32'(wl), exp_l & 32'hFFFF);
      check($sformatf("left_tail[%0d]", frame_no), 32'(tl), 0);
      run_half(1'b1, rst_bit, wr, tr);
      if (rst_bit < 0) begin
         check($sformatf("right_word[%0d]", frame_no), 32'(wr), exp_r & 32'hFFFF);
         check($sformatf("right_tail[%0d]", frame_no), 32'(tr), 0);
      end else begin
         for (int i = 0; i < CH; i++) m_phase[i] = '0;
         m_prev_l = 0;
         m_prev_r = 0;
      end
      frame_no++;
   endtask

   task automatic set_voice(input int i, input logic [AW-1:0] inc, input logic [1:0] mode,
                            input logic right, input logic en);
      ch_inc[i*AW +: AW] = inc;
      ch_mode[2*i +: 2]  = mode;
      ch_right[i]        = right;
      ch_en[i]           = en;
   endtask

   initial begin
      for (int i = 0; i < CH; i++) m_phase[i] = '0;
      for (int i = 0; i < CH; i++) set_voice(i, '0, 2'd0, 1'b0, 1'b1);
      repeat (4) @(negedge clk);
      check("reset_dacdat_init", 32'(dacdat), 0);
      check("reset_frame_pulse_init", 32'(frame_pulse), 0);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      // all-square, all-left, zero increment: full-scale positive mix
      repeat (3) run_frame(-1);

      // one voice toggling sign every frame, rest muted and disabled
      for (int i = 1; i < CH; i++) set_voice(i, '0, 2'd3, 1'b0, 1'b0);
      set_voice(0, 24'h800000, 2'd0, 1'b0, 1'b1);
      repeat (4) run_frame(-1);

      // saw on the right side, disabled then re-enabled to exercise phase freeze
      set_voice(1, 24'h0C3501, 2'd1, 1'b1, 1'b1);
      set_voice(2, 24'h051EB8, 2'd2, 1'b1, 1'b1);
      repeat (2) run_frame(-1);
      ch_en[1] = 1'b0;
      repeat (2) run_frame(-1);
      ch_en[1] = 1'b1;
      repeat (2) run_frame(-1);

      repeat (16) begin
         for (int i = 0; i < CH; i++) begin
            set_voice(i, AW'($urandom), 2'($urandom_range(0, 3)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0));
         end
         run_frame(-1);
      end

      // reset pulse in the middle of a right word, then recovery
      run_frame(6);
      repeat (3) run_frame(-1);

      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule
